// File: rtl/qspi_psram_pkg.sv
// rtl/qspi_psram_pkg.sv - opcodes, FSM state type and timing constants for qspi_psram_arb
package qspi_psram_pkg;

  localparam logic [7:0]  OP_QREAD  = 8'hEB;
  localparam logic [7:0]  OP_QWRITE = 8'h38;
  localparam int unsigned DESEL_CYC = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_DATA,
    ST_DESEL
  } state_e;

endpackage

// File: rtl/qspi_nib_shifter.sv
// rtl/qspi_nib_shifter.sv - 16-bit load/shift register, nibble out at the MSB end, nibble in at the LSB end
module qspi_nib_shifter (
  input  logic        clk,
  input  logic        bacreset,
  input  logic        load_i,
  input  logic [15:0] load_data_i,
  input  logic        shift_i,
  input  logic [3:0]  nib_i,
  output logic [3:0]  nib_o,
  output logic [3:0]  low_nib_o
);

  logic [15:0] sr_q;

  always_ff @(posedge clk or posedge bacreset) begin
    if (bacreset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[11:0], nib_i};
    end
  end

  assign nib_o     = sr_q[15:12];
  assign low_nib_o = sr_q[3:0];

endmodule

// File: rtl/qspi_psram_arb.sv
// rtl/qspi_psram_arb.sv - QPI PSRAM line scheduler: video bursts into a line buffer, then CPU byte slots
// Optional PSRAM_PAGE_WRAP_EN keeps video bursts inside the 2 KB page of vid_base.
module qspi_psram_arb
  import qspi_psram_pkg::*;
#(
  parameter int unsigned AW         = 24,
  parameter int unsigned BURSTS     = 5,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned WAIT_CYC   = 6,
  parameter int unsigned SLOT_LIMIT = 229,
  parameter int unsigned VBUF_AW    = 7
) (
  input  logic               clk,
  input  logic               bacreset,
  input  logic               line_start,
  input  logic [AW-1:0]      vid_base,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack,
  output logic               vbuf_we,
  output logic [VBUF_AW-1:0] vbuf_addr,
  output logic [7:0]         vbuf_data,
  output logic               ps_cs_n,
  output logic               ps_sck_en,
  output logic               qio_oe,
  output logic [3:0]         qio_out,
  input  logic [3:0]         qio_in,
  output logic               slots_left
);

  localparam int unsigned ADDR_NIB = AW / 4;
  localparam int unsigned SW       = $clog2(SLOT_LIMIT + 1);
  localparam int unsigned BW       = $clog2(BURSTS + 1);
  localparam int unsigned BL_SH    = $clog2(BURST_LEN);

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic               is_vid_q, is_wr_q;
  logic [BW-1:0]      burst_idx_q;
  logic [SW-1:0]      slot_cnt_q;
  logic [AW-1:0]      vid_base_q, addr_sr_q;
  logic [7:0]         wdata_q;
  logic               cs_n_q, sck_en_q, oe_q, ack_q, vbuf_we_q;
  logic [7:0]         rdata_q, vbuf_data_q;
  logic [VBUF_AW-1:0] vbuf_addr_q;

  logic [AW-1:0] vid_addr;
  logic          vid_pending, start_vid, start_cpu, chunk_ld;
  logic          sh_load, sh_shift;
  logic [15:0]   sh_ld_data;
  logic [3:0]    sh_nib, sh_low;
  logic [7:0]    rx_byte, data_last;

`ifdef PSRAM_PAGE_WRAP_EN
  logic [10:0] page_off;
  assign page_off = 11'(burst_idx_q) << BL_SH;
  assign vid_addr = {vid_base_q[AW-1:11], vid_base_q[10:0] + page_off};
`else
  logic [AW-1:0] burst_off;
  assign burst_off = AW'(burst_idx_q) << BL_SH;
  assign vid_addr  = vid_base_q + burst_off;
`endif

  assign slots_left  = slot_cnt_q < SW'(SLOT_LIMIT);
  assign vid_pending = burst_idx_q < BW'(BURSTS);
  // A line_start cycle never launches a transaction, so the new line's video wins the next IDLE.
  assign start_vid   = (state_q == ST_IDLE) && !line_start && vid_pending;
  assign start_cpu   = (state_q == ST_IDLE) && !line_start && !vid_pending && cpu_req && slots_left;
  assign rx_byte     = {sh_low, qio_in};
  assign data_last   = is_vid_q ? 8'(2 * BURST_LEN - 1) : 8'd1;

  // The 16-bit shifter holds four address nibbles at a time; reload it every fourth nibble.
  assign chunk_ld = ((state_q == ST_CMD) && (cnt_q == 8'd1)) ||
                    ((state_q == ST_ADDR) && (cnt_q != 8'(ADDR_NIB - 1)) && (cnt_q[1:0] == 2'd3));

  always_comb begin
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_ld_data = '0;
    if (start_vid || start_cpu) begin
      sh_load    = 1'b1;
      sh_ld_data = {(start_cpu && cpu_we) ? OP_QWRITE : OP_QREAD, 8'h00};
    end else if (chunk_ld) begin
      sh_load    = 1'b1;
      sh_ld_data = addr_sr_q[AW-1 -: 16];
    end else if ((state_q == ST_ADDR) && (cnt_q == 8'(ADDR_NIB - 1))) begin
      sh_load    = is_wr_q;
      sh_ld_data = {wdata_q, 8'h00};
    end else if (state_q inside {ST_CMD, ST_ADDR, ST_DATA}) begin
      sh_shift   = 1'b1;
    end
  end

  qspi_nib_shifter u_shifter (
    .clk         (clk),
    .bacreset    (bacreset),
    .load_i      (sh_load),
    .load_data_i (sh_ld_data),
    .shift_i     (sh_shift),
    .nib_i       (qio_in),
    .nib_o       (sh_nib),
    .low_nib_o   (sh_low)
  );

  always_ff @(posedge clk or posedge bacreset) begin
    if (bacreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_vid_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      burst_idx_q <= BW'(BURSTS);
      slot_cnt_q  <= '0;
      vid_base_q  <= '0;
      addr_sr_q   <= '0;
      wdata_q     <= '0;
      cs_n_q      <= 1'b1;
      sck_en_q    <= 1'b0;
      oe_q        <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      vbuf_we_q   <= 1'b0;
      vbuf_addr_q <= '0;
      vbuf_data_q <= '0;
    end else begin
      ack_q     <= 1'b0;
      vbuf_we_q <= 1'b0;
      if (vbuf_we_q) vbuf_addr_q <= vbuf_addr_q + 1'b1;
      if (chunk_ld)  addr_sr_q   <= addr_sr_q << 16;
      case (state_q)
        ST_IDLE: begin
          if (start_vid || start_cpu) begin
            state_q   <= ST_CMD;
            cnt_q     <= '0;
            cs_n_q    <= 1'b0;
            sck_en_q  <= 1'b1;
            oe_q      <= 1'b1;
            is_vid_q  <= start_vid;
            is_wr_q   <= start_cpu && cpu_we;
            wdata_q   <= cpu_wdata;
            addr_sr_q <= start_vid ? vid_addr : cpu_addr;
            if (slot_cnt_q != SW'(SLOT_LIMIT)) slot_cnt_q <= slot_cnt_q + 1'b1;
            if (start_vid) burst_idx_q <= burst_idx_q + 1'b1;
          end
        end
        ST_CMD: begin
          if (cnt_q == 8'd1) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_ADDR: begin
          if (cnt_q == 8'(ADDR_NIB - 1)) begin
            cnt_q <= '0;
            if (is_wr_q) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_WAIT;
              oe_q    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 8'(WAIT_CYC - 1)) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q[0] && !is_wr_q) begin
            vbuf_we_q   <= is_vid_q;
            vbuf_data_q <= rx_byte;
          end
          if (cnt_q == data_last) begin
            state_q  <= ST_DESEL;
            cnt_q    <= '0;
            cs_n_q   <= 1'b1;
            sck_en_q <= 1'b0;
            oe_q     <= 1'b0;
            if (!is_vid_q) begin
              ack_q <= 1'b1;
              if (!is_wr_q) rdata_q <= rx_byte;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DESEL: begin
          if (cnt_q == 8'(DESEL_CYC - 1)) state_q <= ST_IDLE;
          else                            cnt_q   <= cnt_q + 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (line_start) begin
        slot_cnt_q  <= '0;
        burst_idx_q <= '0;
        vbuf_addr_q <= '0;
        vid_base_q  <= vid_base;
      end
    end
  end

  assign ps_cs_n   = cs_n_q;
  assign ps_sck_en = sck_en_q;
  assign qio_oe    = oe_q;
  assign qio_out   = oe_q ? sh_nib : 4'h0;
  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign vbuf_we   = vbuf_we_q;
  assign vbuf_addr = vbuf_addr_q;
  assign vbuf_data = vbuf_data_q;

endmodule
